// File: rtl/interrupt_dispatcher.sv
// Interrupt dispatcher: edge-detects latched source states into pending flags,
// arbitrates by fixed priority and runs an IRQ / ack / done handshake.
//
// Ports:
//   CLK, CLR          clock, async active-low reset
//   Src_State[4:0]    latched sources: [0]=North_Button, [1..4]=Sw0..Sw3
//   Int_Enable        global enable for new requests
//   Mask_Data/Write   mask load (bit i = 1 enables source i)
//   Int_Ack/Int_Done  processor acknowledge / return-from-interrupt
//   IRQ, Int_Cause, Int_Vector   request and its cause/vector
//   Int_Pending       raw pending flags
//   Src_Clear         one-cycle clear strobe per source
//   Busy              high while a request is outstanding or being serviced
module interrupt_dispatcher #(
    parameter int                   VEC_WIDTH  = 16,
    parameter logic [VEC_WIDTH-1:0] VEC_BASE   = 16'h0100,
    parameter logic [VEC_WIDTH-1:0] VEC_STRIDE = 16'h0010
) (
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic [4:0]           Src_State,
    input  logic                 Int_Enable,
    input  logic [4:0]           Mask_Data,
    input  logic                 Mask_Write,
    input  logic                 Int_Ack,
    input  logic                 Int_Done,
    output logic                 IRQ,
    output logic [2:0]           Int_Cause,
    output logic [VEC_WIDTH-1:0] Int_Vector,
    output logic [4:0]           Int_Pending,
    output logic [4:0]           Src_Clear,
    output logic                 Busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQUEST,
        S_SERVICE
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [4:0] prev;
    logic [4:0] mask;
    logic [4:0] pending;
    logic [4:0] rise;
    logic [4:0] armed;
    logic [4:0] clr_bits;
    logic [2:0] cause;
    logic [2:0] winner;
    logic       take;
    logic       ack_hit;

    assign rise  = Src_State & ~prev;
    assign armed = pending & mask;

    // Lowest index wins.
    always_comb begin
        winner = 3'd0;
        priority case (1'b1)
            armed[0]: winner = 3'd0;
            armed[1]: winner = 3'd1;
            armed[2]: winner = 3'd2;
            armed[3]: winner = 3'd3;
            armed[4]: winner = 3'd4;
            default:  winner = 3'd0;
        endcase
    end

    assign take     = (state == S_IDLE) && Int_Enable && (|armed);
    assign ack_hit  = (state == S_REQUEST) && Int_Ack;
    assign clr_bits = ack_hit ? (5'b00001 << cause) : 5'b00000;

    // State register
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (take) state_nxt = S_REQUEST;
            end
            S_REQUEST: begin
                if (Int_Ack) state_nxt = S_SERVICE;
            end
            S_SERVICE: begin
                if (Int_Done) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        IRQ  = 1'b0;
        Busy = 1'b0;
        unique case (state)
            S_IDLE:    ;
            S_REQUEST: begin
                IRQ  = 1'b1;
                Busy = 1'b1;
            end
            S_SERVICE: Busy = 1'b1;
            default:   ;
        endcase
    end

    // Datapath. A fresh edge in the clear cycle re-sets the bit (set wins).
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            prev      <= '0;
            mask      <= '0;
            pending   <= '0;
            cause     <= '0;
            Src_Clear <= '0;
        end else begin
            prev      <= Src_State;
            pending   <= (pending & ~clr_bits) | rise;
            Src_Clear <= clr_bits;
            if (Mask_Write) mask <= Mask_Data;
            if (take) cause <= winner;
        end
    end

    assign Int_Cause   = cause;
    assign Int_Pending = pending;
    assign Int_Vector  = VEC_BASE + VEC_WIDTH'(cause) * VEC_STRIDE;

endmodule

// File: tb/tb_interrupt_dispatcher.sv
// Bench for interrupt_dispatcher: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the dispatcher.
module tb_interrupt_dispatcher;

    logic        CLK = 1'b0;
    logic        CLR;
    logic [4:0]  Src_State;
    logic        Int_Enable;
    logic [4:0]  Mask_Data;
    logic        Mask_Write;
    logic        Int_Ack;
    logic        Int_Done;
    logic        IRQ;
    logic [2:0]  Int_Cause;
    logic [15:0] Int_Vector;
    logic [4:0]  Int_Pending;
    logic [4:0]  Src_Clear;
    logic        Busy;

    int n_vec = 0;
    int n_err = 0;

    localparam int M_IDLE = 0;
    localparam int M_REQ  = 1;
    localparam int M_SVC  = 2;

    int       m_mode;
    int       m_cause;
    bit [4:0] m_prev;
    bit [4:0] m_pend;
    bit [4:0] m_mask;
    bit [4:0] m_clr;

    interrupt_dispatcher dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .Src_State  (Src_State),
        .Int_Enable (Int_Enable),
        .Mask_Data  (Mask_Data),
        .Mask_Write (Mask_Write),
        .Int_Ack    (Int_Ack),
        .Int_Done   (Int_Done),
        .IRQ        (IRQ),
        .Int_Cause  (Int_Cause),
        .Int_Vector (Int_Vector),
        .Int_Pending(Int_Pending),
        .Src_Clear  (Src_Clear),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_cause = 0;
        m_prev  = '0;
        m_pend  = '0;
        m_mask  = '0;
        m_clr   = '0;
    endtask

    task automatic check_all();
        logic [15:0] vec;
        vec = 16'h0100 + 16'(m_cause) * 16'h0010;
        chk("irq",     {15'b0, IRQ},  {15'b0, m_mode == M_REQ});
        chk("busy",    {15'b0, Busy}, {15'b0, m_mode != M_IDLE});
        chk("cause",   {13'b0, Int_Cause}, 16'(m_cause));
        chk("vector",  Int_Vector, vec);
        chk("pending", {11'b0, Int_Pending}, {11'b0, m_pend});
        chk("clear",   {11'b0, Src_Clear},   {11'b0, m_clr});
    endtask

    // One clock: predict from pre-edge inputs, then compare after the edge.
    task automatic step();
        bit [4:0] rise, clrb, nmask, src;
        int       nmode, ncause;
        src    = Src_State;
        rise   = src & ~m_prev;
        clrb   = '0;
        nmode  = m_mode;
        ncause = m_cause;
        nmask  = Mask_Write ? Mask_Data : m_mask;
        case (m_mode)
            M_IDLE: if (Int_Enable && (m_pend & m_mask) != 0) begin
                for (int i = 4; i >= 0; i--)
                    if (m_pend[i] && m_mask[i]) ncause = i;
                nmode = M_REQ;
            end
            M_REQ: if (Int_Ack) begin
                clrb  = 5'(1 << m_cause);
                nmode = M_SVC;
            end
            default: if (Int_Done) nmode = M_IDLE;
        endcase
        @(posedge CLK);
        #1;
        m_pend  = (m_pend & ~clrb) | rise;
        m_clr   = clrb;
        m_prev  = src;
        m_mask  = nmask;
        m_mode  = nmode;
        m_cause = ncause;
        check_all();
    endtask

    task automatic ack_step();
        Int_Ack = 1'b1;
        step();
        Int_Ack = 1'b0;
    endtask

    task automatic done_step();
        Int_Done = 1'b1;
        step();
        Int_Done = 1'b0;
    endtask

    initial begin
        CLR        = 1'b0;
        Src_State  = '0;
        Int_Enable = 1'b0;
        Mask_Data  = '0;
        Mask_Write = 1'b0;
        Int_Ack    = 1'b0;
        Int_Done   = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge CLK);
        CLR = 1'b1;

        // Enable everything
        Mask_Data  = 5'b11111;
        Mask_Write = 1'b1;
        step();
        Mask_Write = 1'b0;
        Int_Enable = 1'b1;

        // Single source 2
        Src_State = 5'b00100;
        step();
        chk("t1_pend", {11'b0, Int_Pending}, 16'h0004);
        chk("t1_irq0", {15'b0, IRQ}, 16'h0000);
        step();
        chk("t1_irq", {15'b0, IRQ}, 16'h0001);
        chk("t1_cause", {13'b0, Int_Cause}, 16'h0002);
        chk("t1_vec", Int_Vector, 16'h0120);
        ack_step();
        chk("t1_clr", {11'b0, Src_Clear}, 16'h0004);
        chk("t1_irq_ack", {15'b0, IRQ}, 16'h0000);
        step();
        chk("t1_clr_off", {11'b0, Src_Clear}, 16'h0000);
        done_step();
        chk("t1_busy", {15'b0, Busy}, 16'h0000);
        Src_State = '0;
        step();

        // Sources 4 and 0 together
        Src_State = 5'b10001;
        step();
        step();
        chk("t2_cause0", {13'b0, Int_Cause}, 16'h0000);
        chk("t2_vec0", Int_Vector, 16'h0100);
        ack_step();
        done_step();
        chk("t2_irq_done", {15'b0, IRQ}, 16'h0000);
        step();
        chk("t2_irq4", {15'b0, IRQ}, 16'h0001);
        chk("t2_cause4", {13'b0, Int_Cause}, 16'h0004);
        chk("t2_vec4", Int_Vector, 16'h0140);
        ack_step();
        done_step();
        Src_State = '0;
        step();

        // Masked source 1, then unmask
        Mask_Data  = 5'b11101;
        Mask_Write = 1'b1;
        step();
        Mask_Write = 1'b0;
        Src_State  = 5'b00010;
        step();
        chk("t3_pend", {11'b0, Int_Pending}, 16'h0002);
        step();
        chk("t3_masked", {15'b0, IRQ}, 16'h0000);
        Mask_Data  = 5'b11111;
        Mask_Write = 1'b1;
        step();
        Mask_Write = 1'b0;
        chk("t3_oldmask", {15'b0, IRQ}, 16'h0000);
        step();
        chk("t3_irq", {15'b0, IRQ}, 16'h0001);
        chk("t3_cause", {13'b0, Int_Cause}, 16'h0001);

        // Re-edge on source 1 in its own ack cycle
        Src_State = '0;
        step();
        Src_State = 5'b00010;
        ack_step();
        chk("t5_keep", {11'b0, Int_Pending}, 16'h0002);
        chk("t5_clr", {11'b0, Src_Clear}, 16'h0002);
        done_step();
        step();
        chk("t5_reirq", {15'b0, IRQ}, 16'h0001);
        chk("t5_cause", {13'b0, Int_Cause}, 16'h0001);
        ack_step();
        done_step();
        Src_State = '0;
        step();

        // Source 3 held high across a full service
        Src_State = 5'b01000;
        step();
        step();
        chk("t4_cause", {13'b0, Int_Cause}, 16'h0003);
        ack_step();
        chk("t4_pend0", {11'b0, Int_Pending}, 16'h0000);
        done_step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_noretrig", {15'b0, IRQ}, 16'h0000);
        end
        Src_State = '0;
        step();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            Src_State  = 5'($urandom);
            Int_Enable = ($urandom % 8) != 0;
            Mask_Write = ($urandom % 16) == 0;
            Mask_Data  = 5'($urandom);
            Int_Ack    = 1'($urandom);
            Int_Done   = ($urandom % 3) == 0;
            step();
        end
        Int_Ack    = 1'b0;
        Int_Done   = 1'b0;
        Mask_Write = 1'b0;
        Int_Enable = 1'b1;
        Src_State  = '0;
        step();
        done_step();
        done_step();

        // Async reset during REQUEST
        Mask_Data  = 5'b11111;
        Mask_Write = 1'b1;
        step();
        Mask_Write = 1'b0;
        Src_State  = 5'b00001;
        for (int i = 0; i < 6 && m_mode != M_REQ; i++) step();
        chk("r_inreq", {15'b0, IRQ}, 16'h0001);
        #3;
        CLR = 1'b0;
        #1;
        chk("r_irq", {15'b0, IRQ}, 16'h0000);
        chk("r_pend", {11'b0, Int_Pending}, 16'h0000);
        chk("r_busy", {15'b0, Busy}, 16'h0000);
        model_reset();
        Mask_Data = '0;
        @(negedge CLK);
        @(negedge CLK);
        CLR = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("r_noirq", {15'b0, IRQ}, 16'h0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
